// File: rtl/iic_bus_monitor.sv
// iic_bus_monitor: conditions raw SCL/SDA pad inputs before they reach axi_iic.
// Synchronises and glitch-filters both lines, detects START/STOP, tracks bus
// busy, captures bytes with their ACK bit and flags SCL held low too long.
//
// Ports:
//   S_AXI_ACLK     in   clock (AXI domain)
//   S_AXI_ARESETN  in   asynchronous active-low reset
//   scl_raw        in   SCL from pad IOBUF
//   sda_raw        in   SDA from pad IOBUF
//   scl_f          out  filtered SCL (to axi_iic scl_i)
//   sda_f          out  filtered SDA (to axi_iic sda_i)
//   start_det      out  1-cycle pulse on any START
//   rep_start      out  1-cycle pulse on START while busy
//   stop_det       out  1-cycle pulse on STOP
//   bus_busy       out  high between START and STOP/timeout
//   byte_done      out  1-cycle pulse after the 9th SCL rise of a byte
//   byte_data[7:0] out  last captured byte, MSB first, held
//   ack_bit        out  SDA at the 9th SCL rise (0 = ACK), held
//   scl_stuck      out  SCL low for TIMEOUT_CYCLES while busy
module iic_bus_monitor #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILT_LEN       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       S_AXI_ACLK,
    input  logic       S_AXI_ARESETN,
    input  logic       scl_raw,
    input  logic       sda_raw,
    output logic       scl_f,
    output logic       sda_f,
    output logic       start_det,
    output logic       rep_start,
    output logic       stop_det,
    output logic       bus_busy,
    output logic       byte_done,
    output logic [7:0] byte_data,
    output logic       ack_bit,
    output logic       scl_stuck
);

    localparam int unsigned FW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);
    localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BW = 4;

    typedef enum logic {IDLE, BUSY} state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic [FW-1:0]          scl_cnt, sda_cnt;
    logic                   scl_q, sda_q;
    logic                   scl_s, sda_s;

    state_t         state, state_n;
    logic [BW-1:0]  bit_cnt, bit_cnt_n;
    logic [7:0]     shreg, shreg_n;
    logic [7:0]     byte_data_n;
    logic           ack_n, byte_done_n, stuck_n;
    logic [TW-1:0]  to_cnt, to_cnt_n;

    logic start_c, stop_c, rise_c;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // Line events from the previous and current filtered values
    assign start_c = scl_q & scl_f & sda_q & ~sda_f;
    assign stop_c  = scl_q & scl_f & ~sda_q & sda_f;
    assign rise_c  = ~scl_q & scl_f;

    // Synchronisers, glitch filters and edge-detect history; reset to idle-high bus
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_cnt  <= '0;
            sda_cnt  <= '0;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_raw};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_raw};
            scl_q    <= scl_f;
            sda_q    <= sda_f;
            if (scl_s != scl_f) begin
                if (scl_cnt == FW'(FILT_LEN - 1)) begin
                    scl_f   <= scl_s;
                    scl_cnt <= '0;
                end else begin
                    scl_cnt <= scl_cnt + FW'(1);
                end
            end else begin
                scl_cnt <= '0;
            end
            if (sda_s != sda_f) begin
                if (sda_cnt == FW'(FILT_LEN - 1)) begin
                    sda_f   <= sda_s;
                    sda_cnt <= '0;
                end else begin
                    sda_cnt <= sda_cnt + FW'(1);
                end
            end else begin
                sda_cnt <= '0;
            end
        end
    end

    // Bus state, byte capture and stuck-low timeout
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        byte_data_n = byte_data;
        ack_n       = ack_bit;
        byte_done_n = 1'b0;
        to_cnt_n    = '0;
        stuck_n     = scl_stuck & ~scl_f;
        case (state)
            IDLE: begin
                if (start_c) begin
                    state_n   = BUSY;
                    bit_cnt_n = '0;
                end
            end
            BUSY: begin
                if (start_c) begin
                    bit_cnt_n = '0;
                end else if (stop_c) begin
                    state_n   = IDLE;
                    bit_cnt_n = '0;
                end else begin
                    if (rise_c) begin
                        if (bit_cnt < BW'(8)) begin
                            shreg_n   = {shreg[6:0], sda_f};
                            bit_cnt_n = bit_cnt + BW'(1);
                        end else begin
                            byte_data_n = shreg;
                            ack_n       = sda_f;
                            byte_done_n = 1'b1;
                            bit_cnt_n   = '0;
                        end
                    end
                    if (!scl_f) begin
                        if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                            stuck_n   = 1'b1;
                            state_n   = IDLE;
                            bit_cnt_n = '0;
                        end else begin
                            to_cnt_n = to_cnt + TW'(1);
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            to_cnt    <= '0;
            start_det <= 1'b0;
            rep_start <= 1'b0;
            stop_det  <= 1'b0;
            bus_busy  <= 1'b0;
            byte_done <= 1'b0;
            byte_data <= '0;
            ack_bit   <= 1'b0;
            scl_stuck <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            to_cnt    <= to_cnt_n;
            start_det <= start_c;
            rep_start <= start_c & (state == BUSY);
            stop_det  <= stop_c;
            bus_busy  <= (state_n == BUSY);
            byte_done <= byte_done_n;
            byte_data <= byte_data_n;
            ack_bit   <= ack_n;
            scl_stuck <= stuck_n;
        end
    end

endmodule

// File: tb/tb_iic_bus_monitor.sv
// Bench for iic_bus_monitor: directed I2C scenarios plus random traffic and
// line noise, checked every cycle against a bit-level bus model.
module tb_iic_bus_monitor;

    localparam int unsigned SYNC = 2;
    localparam int unsigned FILT = 4;
    localparam int unsigned TMO  = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_raw = 1'b1;
    logic       sda_raw = 1'b1;
    logic       scl_f, sda_f, start_det, rep_start, stop_det, bus_busy;
    logic       byte_done, ack_bit, scl_stuck;
    logic [7:0] byte_data;

    always #5 clk = ~clk;

    iic_bus_monitor #(
        .SYNC_STAGES   (SYNC),
        .FILT_LEN      (FILT),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .scl_raw      (scl_raw),
        .sda_raw      (sda_raw),
        .scl_f        (scl_f),
        .sda_f        (sda_f),
        .start_det    (start_det),
        .rep_start    (rep_start),
        .stop_det     (stop_det),
        .bus_busy     (bus_busy),
        .byte_done    (byte_done),
        .byte_data    (byte_data),
        .ack_bit      (ack_bit),
        .scl_stuck    (scl_stuck)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit       mq_scl[$], mq_sda[$];
    bit       m_scl_f, m_sda_f, m_scl_q, m_sda_q;
    int       run_scl, run_sda;
    bit       m_busy, m_start, m_rep, m_stop, m_bd, m_ack, m_stuck;
    bit [7:0] m_data;
    bit       m_bits[$];
    int       m_low;

    task automatic model_reset();
        mq_scl.delete();
        mq_sda.delete();
        for (int i = 0; i < int'(SYNC); i++) begin
            mq_scl.push_back(1'b1);
            mq_sda.push_back(1'b1);
        end
        m_scl_f = 1; m_sda_f = 1; m_scl_q = 1; m_sda_q = 1;
        run_scl = 0; run_sda = 0;
        m_busy = 0; m_start = 0; m_rep = 0; m_stop = 0; m_bd = 0;
        m_ack = 0; m_stuck = 0; m_data = 0; m_low = 0;
        m_bits.delete();
    endtask

    task automatic model_step(input bit rscl, input bit rsda);
        bit ss, sd, cs, cd, os, od, st, sp, ri;
        ss = mq_scl.pop_front(); mq_scl.push_back(rscl);
        sd = mq_sda.pop_front(); mq_sda.push_back(rsda);
        cs = m_scl_f; cd = m_sda_f; os = m_scl_q; od = m_sda_q;
        st = os & cs & od & ~cd;
        sp = os & cs & ~od & cd;
        ri = ~os & cs;
        m_start = st;
        m_rep   = st & m_busy;
        m_stop  = sp;
        m_bd    = 0;
        if (cs) m_stuck = 0;
        if (st) begin
            m_busy = 1;
            m_bits.delete();
        end else if (m_busy) begin
            if (sp) begin
                m_busy = 0;
                m_bits.delete();
            end else if (ri) begin
                if (m_bits.size() < 8) m_bits.push_back(cd);
                else begin
                    m_data = 0;
                    foreach (m_bits[i]) m_data = {m_data[6:0], m_bits[i]};
                    m_ack = cd;
                    m_bd  = 1;
                    m_bits.delete();
                end
            end
        end
        if (m_busy && !cs) begin
            m_low++;
            if (m_low == int'(TMO)) begin
                m_stuck = 1;
                m_busy  = 0;
                m_bits.delete();
                m_low   = 0;
            end
        end else begin
            m_low = 0;
        end
        // a line follows its synchronised input after FILT consecutive disagreeing cycles
        m_scl_q = cs;
        m_sda_q = cd;
        if (ss != m_scl_f) begin
            run_scl++;
            if (run_scl == int'(FILT)) begin m_scl_f = ss; run_scl = 0; end
        end else run_scl = 0;
        if (sd != m_sda_f) begin
            run_sda++;
            if (run_sda == int'(FILT)) begin m_sda_f = sd; run_sda = 0; end
        end else run_sda = 0;
    endtask

    initial model_reset();

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else model_step(scl_raw, sda_raw);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("scl_f", scl_f, m_scl_f);
            chk("sda_f", sda_f, m_sda_f);
            chk("start_det", start_det, m_start);
            chk("rep_start", rep_start, m_rep);
            chk("stop_det", stop_det, m_stop);
            chk("bus_busy", bus_busy, m_busy);
            chk("byte_done", byte_done, m_bd);
            chk("byte_data", byte_data, m_data);
            chk("ack_bit", ack_bit, m_ack);
            chk("scl_stuck", scl_stuck, m_stuck);
        end
    end

    // ---------------- DUT event log for directed checks ----------------
    bit [8:0] log_q[$];
    int n_start = 0, n_rep = 0, n_stop = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (byte_done === 1'b1) log_q.push_back({ack_bit, byte_data});
            if (start_det === 1'b1) n_start++;
            if (rep_start === 1'b1) n_rep++;
            if (stop_det === 1'b1)  n_stop++;
        end
    end

    task automatic clr_log();
        log_q.delete();
        n_start = 0; n_rep = 0; n_stop = 0;
    endtask

    function automatic bit [8:0] log_at(input int i);
        if (i < log_q.size()) return log_q[i];
        return 9'h1FF;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic hold(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic i2c_start(input int p);
        sda_raw = 1; scl_raw = 1; hold(p / 2);
        sda_raw = 0; hold(p / 4);
        scl_raw = 0; hold(p / 4);
    endtask

    task automatic i2c_bit(input bit b, input int p);
        sda_raw = b; hold(p / 4);
        scl_raw = 1; hold(p / 2);
        scl_raw = 0; hold(p / 4);
    endtask

    task automatic i2c_byte(input logic [7:0] d, input bit ack, input int p);
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], p);
        i2c_bit(ack, p);
    endtask

    task automatic i2c_stop(input int p);
        sda_raw = 0; hold(p / 4);
        scl_raw = 1; hold(p / 4);
        sda_raw = 1; hold(p / 2);
    endtask

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  lat, t_fall, t_stuck;
        bit  moved, busy_at_stuck;

        // 1: reset state and short SDA glitch
        rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_scl_f", scl_f, 1);
        chk("rst_sda_f", sda_f, 1);
        chk("rst_bus_busy", bus_busy, 0);
        #3 rst_n = 1;
        cmp_en = 1;
        hold(4);
        sda_raw = 0; hold(3);
        sda_raw = 1;
        moved = 0;
        repeat (12) begin
            @(negedge clk);
            if (sda_f !== 1'b1) moved = 1;
        end
        #1;
        chk("glitch_dropped", moved, 0);

        // 2: START latency and pulse
        sda_raw = 0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (sda_f === 1'b0) begin lat = i; break; end
        end
        chk("start_latency", lat, 6);
        @(negedge clk);
        chk("start_det_pulse", start_det, 1);
        chk("busy_after_start", bus_busy, 1);
        #1;
        scl_raw = 0; hold(10);
        i2c_stop(40);
        hold(10);

        // 3: single byte 0xA5 with ACK
        clr_log();
        i2c_start(40);
        i2c_byte(8'hA5, 1'b0, 40);
        i2c_stop(40);
        hold(20);
        chk("t3_byte_count", log_q.size(), 1);
        chk("t3_byte", log_at(0), {1'b0, 8'hA5});
        chk("t3_stop_count", n_stop, 1);
        chk("t3_idle", bus_busy, 0);

        // 4: byte + NACK, repeated START, byte + ACK
        clr_log();
        i2c_start(40);
        i2c_byte(8'h3C, 1'b1, 40);
        i2c_start(40);
        i2c_byte(8'hFF, 1'b0, 40);
        i2c_stop(40);
        hold(20);
        chk("t4_rep_count", n_rep, 1);
        chk("t4_start_count", n_start, 2);
        chk("t4_byte_count", log_q.size(), 2);
        chk("t4_byte0", log_at(0), {1'b1, 8'h3C});
        chk("t4_byte1", log_at(1), {1'b0, 8'hFF});

        // 5: SCL stuck low after START
        sda_raw = 1; scl_raw = 1; hold(20);
        sda_raw = 0; hold(10);
        scl_raw = 0;
        t_fall = 0; t_stuck = 0; busy_at_stuck = 1;
        for (int i = 1; i <= 150; i++) begin
            @(negedge clk);
            if (t_fall == 0 && scl_f === 1'b0) t_fall = i;
            if (t_stuck == 0 && scl_stuck === 1'b1) begin
                t_stuck = i;
                busy_at_stuck = bus_busy;
            end
        end
        #1;
        chk("t5_stuck_latency", t_stuck - t_fall, TMO);
        chk("t5_busy_at_stuck", busy_at_stuck, 0);
        scl_raw = 1; hold(10);
        chk("t5_stuck_cleared", scl_stuck, 0);
        sda_raw = 1; hold(20);

        // 6: reset in the middle of a byte
        i2c_start(40);
        i2c_bit(1, 40); i2c_bit(0, 40); i2c_bit(1, 40); i2c_bit(1, 40);
        #2;
        rst_n = 0; scl_raw = 1; sda_raw = 1;
        @(negedge clk);
        chk("t6_scl_f", scl_f, 1);
        chk("t6_sda_f", sda_f, 1);
        chk("t6_busy", bus_busy, 0);
        chk("t6_start", start_det, 0);
        chk("t6_byte_data", byte_data, 0);
        chk("t6_ack", ack_bit, 0);
        chk("t6_byte_done", byte_done, 0);
        chk("t6_stuck", scl_stuck, 0);
        repeat (2) @(negedge clk);
        #3 rst_n = 1;
        clr_log();
        hold(20);
        chk("t6_no_pulses", n_start + n_stop + n_rep + log_q.size(), 0);
        i2c_start(40);
        i2c_byte(8'h96, 1'b1, 40);
        i2c_stop(40);
        hold(20);
        chk("t6_byte", log_at(0), {1'b1, 8'h96});

        // random transactions, glitches and raw noise against the model
        for (int t = 0; t < 25; t++) begin
            int p, nb;
            p  = 4 * $urandom_range(5, 12);
            nb = $urandom_range(1, 2);
            i2c_start(p);
            for (int b = 0; b < nb; b++) i2c_byte(8'($urandom), 1'($urandom), p);
            if ($urandom_range(0, 3) == 0) begin
                i2c_start(p);
                i2c_byte(8'($urandom), 1'($urandom), p);
            end
            i2c_stop(p);
            if ($urandom_range(0, 1) == 1) begin
                sda_raw = 0; hold($urandom_range(1, FILT - 1));
                sda_raw = 1; hold(10);
            end
            if ($urandom_range(0, 1) == 1) begin
                scl_raw = 0; hold($urandom_range(1, FILT - 1));
                scl_raw = 1; hold(10);
            end
            hold($urandom_range(5, 20));
        end
        repeat (400) begin
            scl_raw = 1'($urandom);
            sda_raw = 1'($urandom);
            hold($urandom_range(1, 8));
        end
        scl_raw = 1; sda_raw = 1;
        hold(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
